psram_ctrl: RTL and testbench

- Timing controller between the handheld's byte-wide bus master (MCU bridge, later the CPU/PPU arbiter) and the asynchronous 16-bit PSRAM pins.
- Accepts single-byte read/write requests, sequences CE/OE/WE/LB/UB with programmable wait states, returns read data with a valid pulse, and manages the ZZ sleep/wake and power-up delay.
- Sits directly downstream of the bus master; its pin-side outputs go to the top-level tristate and pin assignments.

---
 rtl/psram_pkg.sv | 27 ++
 rtl/psram_ctrl_if.sv | 22 ++
 rtl/psram_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_psram_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM timing controller: FSM state encoding,
// byte-lane select values and a constant-safe ceil(log2) helper.
package psram_pkg;

  typedef enum logic [2:0] {
    ST_WAKE,
    ST_IDLE,
    ST_SETUP,
    ST_RD_ACC,
    ST_WR_ACC,
    ST_RECOV,
    ST_SLEEP
  } state_e;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/psram_ctrl_if.sv
// Byte-wide host bus between the bus master and the PSRAM controller.
interface psram_ctrl_if;

  logic [22:0] host_addr;
  logic        host_rd;
  logic        host_wr;
  logic [7:0]  host_wdata;
  logic        host_ready;
  logic [7:0]  host_rdata;
  logic        host_rvalid;

  modport master (
    output host_addr, host_rd, host_wr, host_wdata,
    input  host_ready, host_rdata, host_rvalid
  );

  modport slave (
    input  host_addr, host_rd, host_wr, host_wdata,
    output host_ready, host_rdata, host_rvalid
  );

endinterface

// File: rtl/psram_ctrl.sv
// Sequences single-byte accesses onto an asynchronous 16-bit PSRAM with
// programmable wait states, plus ZZ sleep handling and the power-up wake delay.
module psram_ctrl
  import psram_pkg::*;
#(
  parameter int RD_CYC   = 2,
  parameter int WR_CYC   = 2,
  parameter int REC_CYC  = 1,
  parameter int WAKE_CYC = 2400
) (
  input  logic         clk,
  input  logic         rst,
  psram_ctrl_if.slave  host,
  input  logic         sleep_req,
  output logic [21:0]  ram_a,
  input  logic [15:0]  ram_dq_i,
  output logic [15:0]  ram_dq_o,
  output logic         ram_dq_oe,
  output logic         ram_ce_n,
  output logic         ram_oe_n,
  output logic         ram_we_n,
  output logic         ram_lb_n,
  output logic         ram_ub_n,
  output logic         ram_zz_n
);

  localparam int MAX_RW  = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int MAX_RWR = (MAX_RW > REC_CYC) ? MAX_RW : REC_CYC;
  localparam int MAX_CYC = (MAX_RWR > WAKE_CYC) ? MAX_RWR : WAKE_CYC;
  localparam int CNT_W   = clog2(MAX_CYC) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t RD_LOAD   = cnt_t'(RD_CYC - 1);
  localparam cnt_t WR_LOAD   = cnt_t'(WR_CYC - 1);
  localparam cnt_t REC_LOAD  = cnt_t'(REC_CYC - 1);
  localparam cnt_t WAKE_LOAD = cnt_t'(WAKE_CYC - 1);

  state_e      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [21:0] addr_q, addr_d;
  logic        lane_q, lane_d;
  logic        wr_q, wr_d;
  logic [15:0] dq_o_q, dq_o_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        ready_q, ready_d;
  logic        dq_oe_q, dq_oe_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        lb_n_q, lb_n_d;
  logic        ub_n_q, ub_n_d;
  logic        zz_n_q, zz_n_d;
  logic        accept;
  logic        active;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    lane_d   = lane_q;
    wr_d     = wr_q;
    dq_o_d   = dq_o_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    accept   = ready_q && (state_q == ST_IDLE) && (host.host_rd || host.host_wr);

    unique case (state_q)
      ST_WAKE: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - cnt_t'(1);
      end
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SETUP;
          addr_d  = host.host_addr[22:1];
          lane_d  = host.host_addr[0];
          // A simultaneous read is dropped: write wins.
          wr_d    = host.host_wr;
          if (host.host_wr) dq_o_d = {host.host_wdata, host.host_wdata};
        end else if (sleep_req) begin
          state_d = ST_SLEEP;
        end
      end
      ST_SETUP: begin
        if (wr_q) begin
          state_d = ST_WR_ACC;
          cnt_d   = WR_LOAD;
        end else begin
          state_d = ST_RD_ACC;
          cnt_d   = RD_LOAD;
        end
      end
      ST_RD_ACC: begin
        if (cnt_q == '0) begin
          rdata_d  = (lane_q == LANE_HI) ? ram_dq_i[15:8] : ram_dq_i[7:0];
          rvalid_d = 1'b1;
          state_d  = ST_RECOV;
          cnt_d    = REC_LOAD;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      ST_WR_ACC: begin
        if (cnt_q == '0) begin
          state_d = ST_RECOV;
          cnt_d   = REC_LOAD;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      ST_RECOV: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - cnt_t'(1);
      end
      ST_SLEEP: begin
        if (!sleep_req) begin
          state_d = ST_WAKE;
          cnt_d   = WAKE_LOAD;
        end
      end
      default: begin
        state_d = ST_WAKE;
        cnt_d   = WAKE_LOAD;
      end
    endcase

    // Pin strobes are decoded from the next state so every pin is a flop output.
    active  = (state_d == ST_SETUP) || (state_d == ST_RD_ACC) || (state_d == ST_WR_ACC);
    ce_n_d  = !active;
    lb_n_d  = !(active && (lane_d == LANE_LO));
    ub_n_d  = !(active && (lane_d == LANE_HI));
    oe_n_d  = !(state_d == ST_RD_ACC);
    we_n_d  = !(state_d == ST_WR_ACC);
    dq_oe_d = wr_d && ((state_d == ST_SETUP) || (state_d == ST_WR_ACC));
    zz_n_d  = (state_d != ST_SLEEP);
    ready_d = (state_d == ST_IDLE) && !sleep_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_WAKE;
      cnt_q    <= WAKE_LOAD;
      addr_q   <= '0;
      lane_q   <= LANE_LO;
      wr_q     <= 1'b0;
      dq_o_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ready_q  <= 1'b0;
      dq_oe_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      zz_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      lane_q   <= lane_d;
      wr_q     <= wr_d;
      dq_o_q   <= dq_o_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ready_q  <= ready_d;
      dq_oe_q  <= dq_oe_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      lb_n_q   <= lb_n_d;
      ub_n_q   <= ub_n_d;
      zz_n_q   <= zz_n_d;
    end
  end

  assign host.host_ready  = ready_q;
  assign host.host_rdata  = rdata_q;
  assign host.host_rvalid = rvalid_q;
  assign ram_a            = addr_q;
  assign ram_dq_o         = dq_o_q;
  assign ram_dq_oe        = dq_oe_q;
  assign ram_ce_n         = ce_n_q;
  assign ram_oe_n         = oe_n_q;
  assign ram_we_n         = we_n_q;
  assign ram_lb_n         = lb_n_q;
  assign ram_ub_n         = ub_n_q;
  assign ram_zz_n         = zz_n_q;

endmodule

// File: tb/tb_psram_ctrl.sv
// Bench for psram_ctrl: pin-level PSRAM model, byte-array reference memory,
// directed vector table, randomized transactions, sleep and mid-access reset.
module tb_psram_ctrl;

  localparam int RD_CYC   = 2;
  localparam int WR_CYC   = 2;
  localparam int REC_CYC  = 1;
  localparam int WAKE_CYC = 4;
  localparam int WINDOW   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sleep_req = 1'b0;
  logic [21:0] ram_a;
  logic [15:0] ram_dq_i;
  logic [15:0] ram_dq_o;
  logic        ram_dq_oe, ram_ce_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n, ram_zz_n;

  psram_ctrl_if bus ();

  psram_ctrl #(
    .RD_CYC(RD_CYC), .WR_CYC(WR_CYC), .REC_CYC(REC_CYC), .WAKE_CYC(WAKE_CYC)
  ) dut (
    .clk(clk), .rst(rst), .host(bus), .sleep_req(sleep_req),
    .ram_a(ram_a), .ram_dq_i(ram_dq_i), .ram_dq_o(ram_dq_o), .ram_dq_oe(ram_dq_oe),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .ram_lb_n(ram_lb_n), .ram_ub_n(ram_ub_n), .ram_zz_n(ram_zz_n)
  );

  always #5 clk = ~clk;

  logic [7:0]  ref_mem [0:31];
  logic [15:0] pin_mem [0:15];
  logic        load_mem = 1'b1;

  // PSRAM pins: data driven only while selected and output-enabled, lane writes on strobe.
  assign ram_dq_i = (!ram_ce_n && !ram_oe_n) ? pin_mem[ram_a[3:0]] : 16'hDEAD;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int w = 0; w < 16; w++) pin_mem[w] <= {ref_mem[2*w+1], ref_mem[2*w]};
    end else if (!ram_ce_n && !ram_we_n && ram_dq_oe) begin
      if (!ram_lb_n) pin_mem[ram_a[3:0]][7:0]  <= ram_dq_o[7:0];
      if (!ram_ub_n) pin_mem[ram_a[3:0]][15:8] <= ram_dq_o[15:8];
    end
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [22:0] addr;
    logic [7:0]  wdata;
    logic [21:0] exp_a;
    logic        exp_lb_n;
    logic        exp_ub_n;
    logic [15:0] exp_dq_o;
    logic        exp_rvalid;
    logic [7:0]  exp_rdata;
  } vec_t;

  int total = 0;
  int bad   = 0;

  int          ob_ce_low, ob_we_low, ob_oe_low, ob_rv_cnt, ob_rv_k, ob_ready_k;
  logic [7:0]  ob_rdata;
  logic [21:0] ob_a;
  logic        ob_lb_n, ob_ub_n, ob_dq_oe;
  logic [15:0] ob_dq_o;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic waitReady();
    int n = 0;
    while (bus.host_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("ready_timeout", 32'(bus.host_ready), 32'd1);
  endtask

  // Issues one request and records what the pins and host side did over a fixed window.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [22:0] addr,
                               input logic [7:0] wdata);
    @(negedge clk);
    waitReady();
    bus.host_addr  = addr;
    bus.host_rd    = rd;
    bus.host_wr    = wr;
    bus.host_wdata = wdata;
    @(posedge clk);
    #1;
    bus.host_rd = 1'b0;
    bus.host_wr = 1'b0;
    ob_ce_low = 0; ob_we_low = 0; ob_oe_low = 0;
    ob_rv_cnt = 0; ob_rv_k = 0; ob_ready_k = 0; ob_rdata = '0;
    for (int k = 1; k <= WINDOW; k++) begin
      @(negedge clk);
      if (!ram_ce_n) ob_ce_low++;
      if (!ram_we_n) ob_we_low++;
      if (!ram_oe_n) ob_oe_low++;
      if (bus.host_rvalid) begin
        ob_rv_cnt++;
        ob_rv_k  = k;
        ob_rdata = bus.host_rdata;
      end
      if (k == 1) begin
        ob_a = ram_a; ob_lb_n = ram_lb_n; ob_ub_n = ram_ub_n;
        ob_dq_oe = ram_dq_oe; ob_dq_o = ram_dq_o;
      end
      if (bus.host_ready && ob_ready_k == 0) ob_ready_k = k;
    end
  endtask

  task automatic runVec(input vec_t v, input string tag);
    int acc;
    acc = v.wr ? WR_CYC : RD_CYC;
    applyStimulus(v.rd, v.wr, v.addr, v.wdata);
    checkOutput({tag, ".ram_a"}, 32'(ob_a), 32'(v.exp_a));
    checkOutput({tag, ".lb_n"}, 32'(ob_lb_n), 32'(v.exp_lb_n));
    checkOutput({tag, ".ub_n"}, 32'(ob_ub_n), 32'(v.exp_ub_n));
    checkOutput({tag, ".dq_oe"}, 32'(ob_dq_oe), 32'(v.wr));
    if (v.wr) checkOutput({tag, ".dq_o"}, 32'(ob_dq_o), 32'(v.exp_dq_o));
    checkOutput({tag, ".ce_low"}, 32'(ob_ce_low), 32'(1 + acc));
    checkOutput({tag, ".we_low"}, 32'(ob_we_low), v.wr ? 32'(WR_CYC) : 32'd0);
    checkOutput({tag, ".oe_low"}, 32'(ob_oe_low), v.wr ? 32'd0 : 32'(RD_CYC));
    checkOutput({tag, ".rvalid_cnt"}, 32'(ob_rv_cnt), 32'(v.exp_rvalid));
    if (v.exp_rvalid) begin
      checkOutput({tag, ".rvalid_lat"}, 32'(ob_rv_k), 32'(2 + RD_CYC));
      checkOutput({tag, ".rdata"}, 32'(ob_rdata), 32'(v.exp_rdata));
    end
    checkOutput({tag, ".ready_ret"}, 32'(ob_ready_k), 32'(2 + acc + REC_CYC));
    if (v.wr) ref_mem[v.addr[4:0]] = v.wdata;
  endtask

  vec_t table_v [6];
  vec_t rv;

  initial begin
    table_v[0] = '{1'b0, 1'b1, 23'h000003, 8'hA5, 22'h000001, 1'b1, 1'b0, 16'hA5A5, 1'b0, 8'h00};
    table_v[1] = '{1'b1, 1'b0, 23'h000002, 8'h00, 22'h000001, 1'b0, 1'b1, 16'h0000, 1'b1, 8'hC3};
    table_v[2] = '{1'b1, 1'b0, 23'h000003, 8'h00, 22'h000001, 1'b1, 1'b0, 16'h0000, 1'b1, 8'hA5};
    table_v[3] = '{1'b1, 1'b1, 23'h000004, 8'h5A, 22'h000002, 1'b0, 1'b1, 16'h5A5A, 1'b0, 8'h00};
    table_v[4] = '{1'b1, 1'b0, 23'h000004, 8'h00, 22'h000002, 1'b0, 1'b1, 16'h0000, 1'b1, 8'h5A};
    table_v[5] = '{1'b1, 1'b0, 23'h000005, 8'h00, 22'h000002, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h77};

    for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i * 37 + 11);
    ref_mem[2] = 8'hC3;
    ref_mem[3] = 8'h12;
    ref_mem[5] = 8'h77;

    bus.host_addr = '0; bus.host_rd = 1'b0; bus.host_wr = 1'b0; bus.host_wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    load_mem = 1'b0;
    checkOutput("rst.rdata", 32'(bus.host_rdata), 32'd0);
    checkOutput("rst.rvalid", 32'(bus.host_rvalid), 32'd0);
    checkOutput("rst.ram_a", 32'(ram_a), 32'd0);
    checkOutput("rst.dq_o", 32'(ram_dq_o), 32'd0);
    checkOutput("rst.dq_oe", 32'(ram_dq_oe), 32'd0);

    rst = 1'b0;
    for (int k = 0; k < WAKE_CYC + 2; k++) begin
      checkOutput($sformatf("wake.ready%0d", k), 32'(bus.host_ready), (k >= WAKE_CYC) ? 32'd1 : 32'd0);
      checkOutput($sformatf("wake.zz_n%0d", k), 32'(ram_zz_n), 32'd1);
      checkOutput($sformatf("wake.strobes%0d", k),
                  32'({ram_ce_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n}), 32'h1F);
      @(negedge clk);
    end

    for (int i = 0; i < 6; i++) runVec(table_v[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 2);
      rv.rd    = (op != 1);
      rv.wr    = (op != 0);
      rv.addr  = 23'($urandom_range(0, 31));
      rv.wdata = 8'($urandom);
      rv.exp_a = rv.addr[22:1];
      rv.exp_lb_n   = rv.addr[0];
      rv.exp_ub_n   = !rv.addr[0];
      rv.exp_dq_o   = {rv.wdata, rv.wdata};
      rv.exp_rvalid = !rv.wr;
      rv.exp_rdata  = ref_mem[rv.addr[4:0]];
      runVec(rv, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Sleep entry and exit.
    waitReady();
    sleep_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("sleep.zz_n%0d", k), 32'(ram_zz_n), 32'd0);
      checkOutput($sformatf("sleep.ready%0d", k), 32'(bus.host_ready), 32'd0);
      checkOutput($sformatf("sleep.ce_n%0d", k), 32'(ram_ce_n), 32'd1);
    end
    sleep_req = 1'b0;
    for (int k = 1; k <= WAKE_CYC + 2; k++) begin
      @(negedge clk);
      checkOutput($sformatf("exit.zz_n%0d", k), 32'(ram_zz_n), 32'd1);
      checkOutput($sformatf("exit.ready%0d", k), 32'(bus.host_ready), (k > WAKE_CYC) ? 32'd1 : 32'd0);
    end

    // Reset landing in the middle of a read access.
    @(negedge clk);
    waitReady();
    bus.host_addr = 23'h000002;
    bus.host_rd   = 1'b1;
    @(posedge clk);
    #1;
    bus.host_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid.oe_active", 32'(ram_oe_n), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid.strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n}), 32'h1F);
    checkOutput("mid.rvalid", 32'(bus.host_rvalid), 32'd0);
    checkOutput("mid.rdata", 32'(bus.host_rdata), 32'd0);
    rst = 1'b0;
    ob_rv_cnt = 0;
    for (int k = 0; k < WAKE_CYC + 2; k++) begin
      if (bus.host_rvalid) ob_rv_cnt++;
      checkOutput($sformatf("mid.ready%0d", k), 32'(bus.host_ready), (k >= WAKE_CYC) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    checkOutput("mid.no_rvalid", 32'(ob_rv_cnt), 32'd0);

    rv = '{1'b1, 1'b0, 23'h000002, 8'h00, 22'h000001, 1'b0, 1'b1, 16'h0000, 1'b1, 8'h00};
    rv.exp_rdata = ref_mem[2];
    runVec(rv, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
